sample_decompressor: RTL and testbench



---
 rtl/sample_decompressor_if.sv | 13 +
 rtl/sample_decompressor.sv | 119 +++++++++++
 tb/tb_sample_decompressor.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_decompressor_if.sv
// Valid/ready channels of sample_decompressor: compressed words in, decompressed sample words out.
interface sample_decompressor_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    // A word moves on a rising edge where valid && ready; the sender holds valid and keeps data stable until ready.
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/sample_decompressor.sv
// Run-length decompressor for the 16-bit sample stream (literal, literal, count -> copies).
// Optional macro SAMPLE_DECOMPRESSOR_COUNT_EN enables the emitted-word counter on sample_count.
module sample_decompressor (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    sample_decompressor_if.slave        bus,
    output logic [31:0]                 sample_count,
    output logic [1:0]                  o_dbg_state
);
    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_LIT    = 2'd1,
        ST_COUNT  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_out_data;
    logic [15:0] r_last;
    logic [15:0] r_rep;
    logic        r_out_valid;
    logic        r_ret;
    logic        w_slot_free;
    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_lit_fire;
    logic        w_cnt_fire;
    logic        w_rep_emit;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_lit_fire  = w_in_fire && ((r_state == ST_FIRST) || (r_state == ST_LIT));
    assign w_cnt_fire  = w_in_fire && (r_state == ST_COUNT);
    assign w_rep_emit  = (r_state == ST_REPEAT) && w_slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FIRST;
        end else if (clear) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FIRST:  if (w_in_fire) w_state_next = ST_LIT;
            ST_LIT:    if (w_in_fire && (bus.in_data == r_last)) w_state_next = ST_COUNT;
            ST_COUNT:  if (w_in_fire) w_state_next = (bus.in_data == 16'h0000) ? ST_FIRST : ST_REPEAT;
            ST_REPEAT: if (w_rep_emit && (r_rep == 16'd1)) w_state_next = r_ret ? ST_COUNT : ST_FIRST;
            default:   w_state_next = ST_FIRST;
        endcase
    end

    // in_ready is a pure function of state and the output slot, never of in_valid.
    always_comb begin
        w_in_ready = (r_state != ST_REPEAT) && w_slot_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= 16'h0000;
            r_out_valid <= 1'b0;
            r_last      <= 16'h0000;
            r_rep       <= 16'h0000;
            r_ret       <= 1'b0;
        end else if (clear) begin
            r_out_data  <= 16'h0000;
            r_out_valid <= 1'b0;
            r_last      <= 16'h0000;
            r_rep       <= 16'h0000;
            r_ret       <= 1'b0;
        end else begin
            if (w_lit_fire) begin
                r_out_data  <= bus.in_data;
                r_out_valid <= 1'b1;
                r_last      <= bus.in_data;
            end else if (w_rep_emit) begin
                r_out_data  <= r_last;
                r_out_valid <= 1'b1;
                r_rep       <= r_rep - 16'd1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            // r_ret set means the run continues with another count word (c == FFFF).
            if (w_cnt_fire && (bus.in_data != 16'h0000)) begin
                r_rep <= bus.in_data;
                r_ret <= (bus.in_data == 16'hFFFF);
            end
        end
    end

`ifdef SAMPLE_DECOMPRESSOR_COUNT_EN
    logic [31:0] r_sample_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_count <= 32'd0;
        end else if (clear) begin
            r_sample_count <= 32'd0;
        end else if (r_out_valid && bus.out_ready) begin
            r_sample_count <= r_sample_count + 32'd1;
        end
    end

    assign sample_count = r_sample_count;
`else
    assign sample_count = 32'd0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_sample_decompressor.sv
// Directed-vector bench for sample_decompressor: stream scenarios, backpressure, flush and reset.
module tb_sample_decompressor;
    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] sample_count;
    logic [1:0]  o_dbg_state;
    int          n_cmp;
    int          n_err;
    logic        bp_mode;
    logic        timeout_hit;
    logic        hold_v;
    logic [15:0] hold_d;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    sample_decompressor_if bus ();

    sample_decompressor dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .bus          (bus),
        .sample_count (sample_count),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // out_ready: always 1, or the repeating 1,0,0,1 pattern when bp_mode is set
    initial begin
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                k++;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // output monitor: records consumed words and checks the slot holds while stalled
    always @(negedge clk) begin
        if (rst || clear) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d) begin
                    n_err++;
                    $display("FAIL hold_stable: got valid=%b data=%h, expected valid=1 data=%h",
                             bus.out_valid, bus.out_data, hold_d);
                end
            end
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            hold_v = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
        end
    end

    // driver tasks
    task automatic send_word(input logic [15:0] w, output int waits);
        int guard;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        waits = 0;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 70000) begin
            waits++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 70000) timeout_hit = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_outputs(input int n, output bit ok);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < n * 4 + 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        ok = (got_q.size() >= n);
        @(posedge clk);
        #1;
    endtask

    // scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 16'h0000;
        #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL rst_out_data: got %h expected 0000", bus.out_data); end
        n_cmp++; if (o_dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d expected 0", o_dbg_state); end
        n_cmp++; if (sample_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", sample_count); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_no_runs();
        logic [15:0] words[3];
        int w;
        bit ok;
        words = '{16'h0001, 16'h0002, 16'h0003};
        do_clear();
        exp_q = '{16'h0001, 16'h0002, 16'h0003};
        for (int i = 0; i < 3; i++) begin
            send_word(words[i], w);
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== words[i]) begin
                n_err++; $display("FAIL lit_latency[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_data, words[i]);
            end
            if (i > 0) begin
                n_cmp++; if (w !== 0) begin n_err++; $display("FAIL back_to_back[%0d]: got %0d stall cycles expected 0", i, w); end
            end
        end
        wait_outputs(3, ok);
        n_cmp++; if (!ok || got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL no_runs_len: got %0d words expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL no_runs_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_short_run(input logic with_bp);
        int w;
        bit ok;
        do_clear();
        bp_mode = with_bp;
        exp_q = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h5555};
        send_word(16'hAAAA, w);
        send_word(16'hAAAA, w);
        send_word(16'h0003, w);
        send_word(16'h5555, w);
        if (!with_bp) begin
            n_cmp++; if (w !== 3) begin n_err++; $display("FAIL repeat_stall: got %0d in_ready-low cycles expected 3", w); end
        end
        wait_outputs(6, ok);
        bp_mode = 1'b0;
        n_cmp++; if (!ok || got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL short_run_len bp=%b: got %0d words expected %0d", with_bp, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL short_run_word[%0d] bp=%b: got %h expected %h", i, with_bp, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_count();
        int w;
        bit ok;
        do_clear();
        exp_q = '{16'h1234, 16'h1234, 16'h1234};
        send_word(16'h1234, w);
        send_word(16'h1234, w);
        send_word(16'h0000, w);
        send_word(16'h1234, w);
        wait_outputs(3, ok);
        n_cmp++; if (!ok || got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL zero_count_len: got %0d words expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL zero_count_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (o_dbg_state !== 2'd1) begin n_err++; $display("FAIL zero_count_state: got %0d expected 1", o_dbg_state); end
    endtask

    task automatic test_long_run();
        int w;
        bit ok;
        logic [31:0] exp_cnt;
        do_clear();
        for (int i = 0; i < 65539; i++) exp_q.push_back(16'h00FF);
        exp_q.push_back(16'h0001);
        send_word(16'h00FF, w);
        send_word(16'h00FF, w);
        send_word(16'hFFFF, w);
        send_word(16'h0002, w);
        n_cmp++; if (w !== 65535) begin n_err++; $display("FAIL long_run_stall: got %0d in_ready-low cycles expected 65535", w); end
        send_word(16'h0001, w);
        wait_outputs(65540, ok);
        n_cmp++; if (!ok || got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL long_run_len: got %0d words expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL long_run_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
`ifdef SAMPLE_DECOMPRESSOR_COUNT_EN
        exp_cnt = 32'd65540;
`else
        exp_cnt = 32'd0;
`endif
        n_cmp++; if (sample_count !== exp_cnt) begin n_err++; $display("FAIL long_run_count: got %0d expected %0d", sample_count, exp_cnt); end
    endtask

    task automatic test_flush(input logic use_rst);
        int w;
        bit ok;
        logic [31:0] exp_cnt;
        do_clear();
        exp_q = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h0007};
        send_word(16'hAAAA, w);
        send_word(16'hAAAA, w);
        send_word(16'h0003, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        if (use_rst) begin
            #2;
            rst = 1'b1;
            #1;
        end else begin
            clear = 1'b1;
            @(posedge clk);
            #1;
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid rst=%b: got %b expected 0", use_rst, bus.out_valid); end
        n_cmp++; if (o_dbg_state !== 2'd0) begin n_err++; $display("FAIL flush_state rst=%b: got %0d expected 0", use_rst, o_dbg_state); end
        if (use_rst) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            clear = 1'b0;
        end
        send_word(16'h0007, w);
        wait_outputs(4, ok);
        n_cmp++; if (!ok || got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL flush_len rst=%b: got %0d words expected %0d", use_rst, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL flush_word[%0d] rst=%b: got %h expected %h", i, use_rst, got_q[i], exp_q[i]); end
        end
`ifdef SAMPLE_DECOMPRESSOR_COUNT_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        n_cmp++; if (sample_count !== exp_cnt) begin n_err++; $display("FAIL flush_count rst=%b: got %0d expected %0d", use_rst, sample_count, exp_cnt); end
    endtask

    // sequence and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        bp_mode = 1'b0;
        timeout_hit = 1'b0;
        hold_v = 1'b0;
        hold_d = 16'h0000;
        test_reset();
        test_no_runs();
        test_short_run(1'b0);
        test_zero_count();
        test_long_run();
        test_short_run(1'b1);
        test_flush(1'b0);
        test_flush(1'b1);
        n_cmp++; if (timeout_hit !== 1'b0) begin n_err++; $display("FAIL in_ready_timeout: got %b expected 0", timeout_hit); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
